// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up and divide-by-zero/overflow shortcuts.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [4:0]  rd_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  rd_out
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state, state_nx;
   logic [5:0]  cnt;
   logic [2:0]  op_q;
   logic [4:0]  rd_q;
   logic [31:0] a_mag, b_mag;
   logic        neg_q, neg_r;
   logic [63:0] acc;

   // Operand decode for the request presented this cycle
   logic        is_div_in, sgn_a_in, sgn_b_in, sa_in, sb_in;
   logic [31:0] a_mag_in, b_mag_in;
   logic        div0, ovf, bypass, accept;
   logic [31:0] bypass_val;

   assign is_div_in = op[2];
   assign sgn_a_in  = is_div_in ? ~op[0] : (op != 3'b011);
   assign sgn_b_in  = is_div_in ? ~op[0] : ~op[1];
   assign sa_in     = sgn_a_in & op_a[31];
   assign sb_in     = sgn_b_in & op_b[31];
   assign a_mag_in  = sa_in ? -op_a : op_a;
   assign b_mag_in  = sb_in ? -op_b : op_b;
   assign div0      = is_div_in && (op_b == 32'd0);
   assign ovf       = is_div_in && !op[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
   assign bypass    = div0 || ovf;
   assign bypass_val = div0 ? (op[1] ? op_a : 32'hFFFF_FFFF)
                            : (op[1] ? 32'd0 : 32'h8000_0000);
   assign accept    = (state == IDLE) && start && !flush;

   // One iteration: multiply adds a_mag into the high half and shifts right;
   // divide shifts left and subtracts b_mag when the trial remainder stays non-negative.
   logic [32:0] mul_sum, div_trial;
   logic [63:0] acc_step;

   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
      div_trial = acc[63:31] - {1'b0, b_mag};
      if (op_q[2])
         acc_step = div_trial[32] ? {acc[62:0], 1'b0} : {div_trial[31:0], acc[30:0], 1'b1};
      else
         acc_step = {mul_sum, acc[31:1]};
   end

   logic [63:0] mul_p;
   logic [31:0] quo, rem, final_val;

   always_comb begin
      mul_p = neg_q ? -acc_step : acc_step;
      quo   = neg_q ? -acc_step[31:0] : acc_step[31:0];
      rem   = neg_r ? -acc_step[63:32] : acc_step[63:32];
      case (op_q)
         3'b000:         final_val = mul_p[31:0];
         3'b100, 3'b101: final_val = quo;
         3'b110, 3'b111: final_val = rem;
         default:        final_val = mul_p[63:32];
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: if (accept) state_nx = bypass ? DONE : CALC;
         CALC: begin
            busy = 1'b1;
            if (cnt == 6'd31) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   // NOTE: datapath registers, accumulators included, are reset so an abandoned
   // operation leaves nothing behind; state updates use non-blocking assignments.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         op_q   <= '0;
         rd_q   <= '0;
         a_mag  <= '0;
         b_mag  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         acc    <= '0;
         result <= '0;
         rd_out <= '0;
      end else if (accept) begin
         cnt   <= '0;
         op_q  <= op;
         rd_q  <= rd_in;
         a_mag <= a_mag_in;
         b_mag <= b_mag_in;
         neg_q <= sa_in ^ sb_in;
         neg_r <= sa_in;
         acc   <= {32'd0, is_div_in ? a_mag_in : b_mag_in};
         if (bypass) begin
            result <= bypass_val;
            rd_out <= rd_in;
         end
      end else if (state == CALC && !flush) begin
         acc <= acc_step;
         cnt <= cnt + 6'd1;
         if (cnt == 6'd31) begin
            result <= final_val;
            rd_out <= rd_q;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an arithmetic reference model checked every cycle,
// plus literal expectations per vector covering latency, flush, reset and held start.
module tb_muldiv_unit;

   localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
   localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

   logic        clk = 1'b0;
   logic        rst, flush, start;
   logic [2:0]  op;
   logic [31:0] op_a, op_b, result;
   logic [4:0]  rd_in, rd_out;
   logic        busy, done;

   int n_vec = 0;
   int n_bad = 0;

   muldiv_unit dut (
      .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
      .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
      .busy(busy), .done(done), .result(result), .rd_out(rd_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] pa, pb, p;
      int sa, sb;
      if (!o[2]) begin
         pa = (o != MULHU)              ? {{32{a[31]}}, a} : {32'd0, a};
         pb = (o == MUL || o == MULH)   ? {{32{b[31]}}, b} : {32'd0, b};
         p  = pa * pb;
         return (o == MUL) ? p[31:0] : p[63:32];
      end
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
         sa = a;
         sb = b;
         return o[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return o[1] ? (a % b) : (a / b);
   endfunction

   function automatic bit is_bypass(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      return o[2] && (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Reference model and per-cycle compare
   bit          pend = 1'b0;
   int          pend_done = 0;
   int          cyc = 0;
   logic [31:0] pend_res, last_res = '0;
   logic [4:0]  pend_rd, last_rd = '0;
   bit          exp_busy, exp_done;

   always begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
         pend     = 1'b0;
         last_res = '0;
         last_rd  = '0;
      end else if (flush) begin
         pend = 1'b0;
      end else if (start && (!pend || cyc > pend_done + 1)) begin
         pend      = 1'b1;
         pend_res  = model(op, op_a, op_b);
         pend_rd   = rd_in;
         pend_done = is_bypass(op, op_a, op_b) ? cyc : cyc + 32;
      end
      #2;
      exp_busy = pend && (cyc < pend_done);
      exp_done = pend && (cyc == pend_done);
      if (exp_done) begin
         last_res = pend_res;
         last_rd  = pend_rd;
      end
      check("busy",   32'(busy),   32'(exp_busy));
      check("done",   32'(done),   32'(exp_done));
      check("result", result,      last_res);
      check("rd_out", 32'(rd_out), 32'(last_rd));
   end

   // Called at a falling edge; leaves the unit idle at a falling edge.
   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_lat);
      int lat;
      start = 1'b1; op = o; op_a = a; op_b = b; rd_in = rd;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " result"}, result, exp);
      check({name, " rd_out"}, 32'(rd_out), 32'(rd));
      check({name, " model"}, model(o, a, b), exp);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int dones;
      rst = 1'b0; flush = 1'b0; start = 1'b0;
      op = '0; op_a = '0; op_b = '0; rd_in = '0;
      repeat (3) @(negedge clk);
      check("reset result", result, 32'd0);
      check("reset busy",   32'(busy), 32'd0);
      rst = 1'b1;

      run_op("mul 7x-3",     MUL,    32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 32);
      run_op("mulh min^2",   MULH,   32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000, 32);
      run_op("mulhu max^2",  MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 32);
      run_op("mulhsu -1xmax",MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 32);
      run_op("mulhu 2^32",   MULHU,  32'h0001_0000,  32'h0001_0000, 5'd7,  32'd1,         32);
      run_op("div -7/2",     DIV,    32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFD, 32);
      run_op("rem -7/2",     REM,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFF, 32);
      run_op("divu 100/7",   DIVU,   32'd100,        32'd7,         5'd10, 32'd14,        32);
      run_op("remu 100/7",   REMU,   32'd100,        32'd7,         5'd11, 32'd2,         32);
      run_op("rem 7/-2",     REM,    32'd7,          32'hFFFF_FFFE, 5'd12, 32'd1,         32);
      run_op("div 5/0",      DIV,    32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 0);
      run_op("remu 5/0",     REMU,   32'd5,          32'd0,         5'd14, 32'd5,         0);
      run_op("div ovf",      DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0);
      run_op("rem ovf",      REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         0);

      // Flush in the middle of a multiply, then restart right after
      start = 1'b1; op = MUL; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd17;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", 32'(busy), 32'd0);
      check("flush done", 32'(done), 32'd0);
      run_op("after flush",  MUL,    32'd3,          32'd5,         5'd18, 32'd15,        32);

      // Start held high: each accepted request yields exactly one done
      start = 1'b1; op = DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd19;
      dones = 0;
      for (int k = 1; k <= 68; k++) begin
         @(negedge clk);
         if (done) dones++;
      end
      start = 1'b0;
      check("held start dones", 32'(dones), 32'd2);
      @(negedge clk);

      // Reset in the middle of a calculation
      start = 1'b1; op = MUL; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd20;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #3 rst = 1'b0;
      #1;
      check("mid reset busy",   32'(busy), 32'd0);
      check("mid reset done",   32'(done), 32'd0);
      check("mid reset result", result,    32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_op("after reset",  DIVU,   32'd100,        32'd7,         5'd21, 32'd14,        32);

      repeat (40) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
